// File: rtl/mdu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_pkg : shared MDU opcode constants, latency defaults, FSM enum  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mdu_pkg;

   localparam logic [3:0] MDU_NONE = 4'd0;
   localparam logic [3:0] MULT     = 4'd1;
   localparam logic [3:0] MULTU    = 4'd2;
   localparam logic [3:0] DIV      = 4'd3;
   localparam logic [3:0] DIVU     = 4'd4;
   localparam logic [3:0] MFHI     = 4'd5;
   localparam logic [3:0] MFLO     = 4'd6;
   localparam logic [3:0] MTHI     = 4'd7;
   localparam logic [3:0] MTLO     = 4'd8;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [0:0] {
      STATE_IDLE = 1'b0,
      STATE_BUSY = 1'b1
   } state_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_e_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_e_if : E-stage operand/issue bus and HI/LO result bus of MDU   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mdu_e_if;
   logic        req;
   logic        start;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUout;

   modport master (output req, start, MDUOp, A, B,
                   input  busy, HI, LO, MDUout);
   modport slave  (input  req, start, MDUOp, A, B,
                   output busy, HI, LO, MDUout);
endinterface
`default_nettype wire

// File: rtl/mdu_calc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_calc : combinational mult/multu/div/divu datapath -> {hi,lo}   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_res,
   output logic        o_div_by_zero
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_den_u;
   logic [31:0] w_den_s;
   logic [31:0] w_q_u;
   logic [31:0] w_r_u;
   logic [31:0] w_q_m;
   logic [31:0] w_r_m;
   logic [31:0] w_q_s;
   logic [31:0] w_r_s;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
   assign w_mag_a = i_a[31] ? (32'd0 - i_a) : i_a;
   assign w_mag_b = i_b[31] ? (32'd0 - i_b) : i_b;
   assign w_den_u = (i_b == 32'd0) ? 32'd1 : i_b;
   assign w_den_s = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;

   assign w_q_u = i_a / w_den_u;
   assign w_r_u = i_a % w_den_u;
   assign w_q_m = w_mag_a / w_den_s;
   assign w_r_m = w_mag_a % w_den_s;
   assign w_q_s = (i_a[31] ^ i_b[31]) ? (32'd0 - w_q_m) : w_q_m;
   assign w_r_s = i_a[31] ? (32'd0 - w_r_m) : w_r_m;

   always_comb begin
      o_res = 64'd0;
      case (i_op)
         MULT:    o_res = w_prod_s;
         MULTU:   o_res = w_prod_u;
         DIV:     o_res = {w_r_s, w_q_s};
         DIVU:    o_res = {w_r_u, w_q_u};
         default: o_res = 64'd0;
      endcase
   end

   assign o_div_by_zero = is_div(i_op) && (i_b == 32'd0);

endmodule
`default_nettype wire

// File: rtl/mdu_e.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | mdu_e : E-stage multiply/divide unit owning HI/LO                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mdu_e
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic    clk,
   input  logic    reset,
   mdu_e_if.slave  bus
);

   localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] phi_q, phi_d;
   logic [31:0] plo_q, plo_d;
   logic        pdbz_q, pdbz_d;

   logic [63:0] w_res;
   logic        w_dbz;

   mdu_calc u_calc (
      .i_op          (bus.MDUOp),
      .i_a           (bus.A),
      .i_b           (bus.B),
      .o_res         (w_res),
      .o_div_by_zero (w_dbz)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      pdbz_d  = pdbz_q;
      case (state_q)
         STATE_IDLE: begin
            if (!bus.req) begin
               if (bus.start && is_muldiv(bus.MDUOp)) begin
                  phi_d   = w_res[63:32];
                  plo_d   = w_res[31:0];
                  pdbz_d  = w_dbz;
                  cnt_d   = is_div(bus.MDUOp) ? C_DIV_CNT : C_MULT_CNT;
                  busy_d  = 1'b1;
                  state_d = STATE_BUSY;
               end else if (bus.MDUOp == MTHI) begin
                  hi_d = bus.A;
               end else if (bus.MDUOp == MTLO) begin
                  lo_d = bus.A;
               end
            end
         end
         STATE_BUSY: begin
            // req is deliberately ignored here: the op in flight is older.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               busy_d  = 1'b0;
               state_d = STATE_IDLE;
               if (!pdbz_q) begin
                  hi_d = phi_q;
                  lo_d = plo_q;
               end
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= STATE_IDLE;
         cnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
         pdbz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         pdbz_q  <= pdbz_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

   always_comb begin
      bus.MDUout = 32'd0;
      if (bus.MDUOp == MFHI)
         bus.MDUout = hi_q;
      else if (bus.MDUOp == MFLO)
         bus.MDUout = lo_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_e.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mdu_e : directed + random bench for mdu_e with arithmetic model |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mdu_e;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   viol = 0;

   mdu_e_if bus();

   mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Issue attempts while busy; only the one deliberate case should occur.
   always @(posedge clk)
      if (reset && bus.busy && (bus.start || bus.MDUOp == MTHI || bus.MDUOp == MTLO))
         viol <= viol + 1;

   // Reference model state: architectural HI/LO plus remaining busy cycles.
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi, m_plo;
   logic        m_pdbz;
   int          m_rem = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_edge();
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      if (!reset) begin
         m_hi = 0; m_lo = 0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0 && !m_pdbz) begin
            m_hi = m_phi; m_lo = m_plo;
         end
      end else if (!bus.req) begin
         if (bus.start && bus.MDUOp >= 4'd1 && bus.MDUOp <= 4'd4) begin
            sa = $signed(bus.A); sb = $signed(bus.B);
            ua = bus.A;          ub = bus.B;
            m_pdbz = 1'b0;
            case (bus.MDUOp)
               MULT:  begin sq = sa * sb; {m_phi, m_plo} = sq; m_rem = 5; end
               MULTU: begin up = ua * ub; {m_phi, m_plo} = up; m_rem = 5; end
               DIV: begin
                  m_rem = 10;
                  if (sb == 0) m_pdbz = 1'b1;
                  else begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
               end
               default: begin
                  m_rem = 10;
                  if (ub == 0) m_pdbz = 1'b1;
                  else begin up = ua / ub; m_plo = up[31:0]; up = ua % ub; m_phi = up[31:0]; end
               end
            endcase
         end else if (bus.MDUOp == MTHI) m_hi = bus.A;
         else if (bus.MDUOp == MTLO) m_lo = bus.A;
      end
   endtask

   task automatic cyc();
      logic [31:0] exp_out;
      @(posedge clk);
      model_edge();
      #1;
      exp_out = (bus.MDUOp == MFHI) ? m_hi : (bus.MDUOp == MFLO) ? m_lo : 32'd0;
      chk("busy", {31'd0, bus.busy}, {31'd0, m_rem > 0});
      chk("HI", bus.HI, m_hi);
      chk("LO", bus.LO, m_lo);
      chk("MDUout", bus.MDUout, exp_out);
   endtask

   task automatic set_in(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = st; bus.MDUOp = op; bus.A = a; bus.B = b;
   endtask

   // Issues one op and counts busy cycles (bounded); req is raised in busy cycle req_at.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int req_at, output int n);
      set_in(1'b1, op, a, b);
      cyc();
      set_in(1'b0, MDU_NONE, 32'd0, 32'd0);
      n = 0;
      while (bus.busy && n < 20) begin
         n++;
         bus.req = (n == req_at);
         cyc();
      end
      bus.req = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      logic [3:0] op;
      reset = 1'b0;
      bus.req = 1'b0;
      set_in(1'b0, MDU_NONE, 32'd0, 32'd0);

      cyc(); cyc();
      reset = 1'b1;
      bus.MDUOp = MFHI;
      cyc();
      chk("rst_hi", bus.HI, 32'd0);
      chk("rst_lo", bus.LO, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mduout", bus.MDUout, 32'd0);

      run_op(MULT, 32'hFFFF_FFFE, 32'd3, 0, n);
      chk("mult_cycles", n, 5);
      chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
      chk("mult_lo", bus.LO, 32'hFFFF_FFFA);

      run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, n);
      chk("div_cycles", n, 10);
      chk("div_lo", bus.LO, 32'hFFFF_FFFD);
      chk("div_hi", bus.HI, 32'hFFFF_FFFF);

      set_in(1'b0, MTHI, 32'h1111_1111, 32'd0); cyc();
      set_in(1'b0, MTLO, 32'h2222_2222, 32'd0); cyc();
      run_op(DIVU, 32'd1234, 32'd0, 0, n);
      chk("dbz_cycles", n, 10);
      chk("dbz_hi", bus.HI, 32'h1111_1111);
      chk("dbz_lo", bus.LO, 32'h2222_2222);

      bus.req = 1'b1;
      set_in(1'b1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      cyc();
      bus.req = 1'b0;
      set_in(1'b0, MDU_NONE, 32'd0, 32'd0);
      cyc();
      chk("req_busy", {31'd0, bus.busy}, 32'd0);
      chk("req_hi", bus.HI, 32'h1111_1111);
      chk("req_lo", bus.LO, 32'h2222_2222);

      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, n);
      chk("multu_req_cycles", n, 5);
      chk("multu_req_hi", bus.HI, 32'hFFFF_FFFE);
      chk("multu_req_lo", bus.LO, 32'h0000_0001);

      set_in(1'b0, MTHI, 32'hDEAD_BEEF, 32'd0); cyc();
      set_in(1'b0, MTLO, 32'h1234_5678, 32'd0); cyc();
      bus.MDUOp = MFHI; #1;
      chk("mfhi", bus.MDUout, 32'hDEAD_BEEF);
      bus.MDUOp = MFLO; #1;
      chk("mflo", bus.MDUout, 32'h1234_5678);

      set_in(1'b1, MULT, 32'd2, 32'd3); cyc();
      set_in(1'b0, MTHI, 32'hCAFE_F00D, 32'd0); cyc();
      set_in(1'b0, MDU_NONE, 32'd0, 32'd0);
      n = 0;
      while (bus.busy && n < 20) begin n++; cyc(); end
      chk("mthi_busy_hi", bus.HI, 32'd0);
      chk("mthi_busy_lo", bus.LO, 32'd6);

      set_in(1'b1, DIV, 32'd100, 32'd7); cyc();
      set_in(1'b0, MDU_NONE, 32'd0, 32'd0);
      cyc(); cyc();
      reset = 1'b0;
      cyc();
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_hi", bus.HI, 32'd0);
      chk("midrst_lo", bus.LO, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) cyc();

      for (int i = 0; i < 800; i++) begin
         reset   = ($urandom_range(0, 99) != 0);
         bus.req = ($urandom_range(0, 9) == 0);
         bus.A   = pick();
         bus.B   = pick();
         if (m_rem == 0) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.MDUOp = bus.start ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
         end else begin
            bus.start = 1'b0;
            case ($urandom_range(0, 3))
               0:       op = MDU_NONE;
               1:       op = MFHI;
               2:       op = MFLO;
               default: op = 4'($urandom_range(9, 15));
            endcase
            bus.MDUOp = op;
         end
         cyc();
      end

      chk("protocol_viol", viol, 1);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
